tile_matrix_scanner: RTL and testbench

//  Parametrised, time-multiplexed driver for the two-colour (p/g) LED tile matrix fed by the game loop.

---
 rtl/tile_matrix_scanner.sv | 187 ++++++++++++++++++
 tb/tb_tile_matrix_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_matrix_scanner.sv
// Time-multiplexed p/g LED tile matrix scanner: anti-ghost blanking, per-tile blink,
// global PWM brightness and a shadow/active double-buffered frame.

module tsm_col_lane (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic drive_i,
  input  logic pwm_on_i,
  input  logic blink_phase_i,
  input  logic p_i,
  input  logic g_i,
  input  logic blink_i,
  output logic col_p_o,
  output logic col_g_o
);
  logic lit;
  logic col_p_q, col_g_q;

  assign lit = drive_i & pwm_on_i & ~(blink_i & blink_phase_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_p_q <= 1'b0;
      col_g_q <= 1'b0;
    end else begin
      col_p_q <= p_i & lit;
      col_g_q <= g_i & lit;
    end
  end

  assign col_p_o = col_p_q;
  assign col_g_o = col_g_q;
endmodule

module tile_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 7,
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int PWM_BITS       = 4,
  parameter int BLINK_DIV_BITS = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 load_i,
  input  logic [ROWS*COLS-1:0] tiles_p_i,
  input  logic [ROWS*COLS-1:0] tiles_g_i,
  input  logic [ROWS*COLS-1:0] blink_mask_i,
  input  logic [PWM_BITS-1:0]  brightness_i,
  output logic [ROWS-1:0]      row_sel_o,
  output logic [COLS-1:0]      col_p_o,
  output logic [COLS-1:0]      col_g_o,
  output logic                 frame_done_o,
  output logic                 busy_o
);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  // Bit r*COLS+c of the flat bitmaps lands on [r][c].
  typedef logic [ROWS-1:0][COLS-1:0] tile_map_t;
  typedef struct packed {
    tile_map_t p;
    tile_map_t g;
    tile_map_t blink;
  } frame_t;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  frame_t              shadow_q, active_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [BLINK_DIV_BITS-1:0] blink_div_q;
  logic                blink_phase_q;
  logic [ROWS-1:0]     row_sel_q;
  logic                frame_done_q, busy_q;
  logic                xfer, frame_end, drive, pwm_on;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    xfer      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = BLANK;
          row_d   = '0;
          cnt_d   = '0;
          xfer    = 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (row_q == ROW_LAST) begin
            row_d     = '0;
            frame_end = 1'b1;
            xfer      = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable wins everywhere and discards the partial frame.
    if (!enable_i) begin
      state_d   = IDLE;
      row_d     = '0;
      cnt_d     = '0;
      xfer      = 1'b0;
      frame_end = 1'b0;
    end
  end

  assign drive  = enable_i & (state_q == DRIVE);
  assign pwm_on = (&brightness_i) | (pwm_cnt_q < brightness_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      row_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pwm_cnt_q     <= '0;
      blink_div_q   <= '0;
      blink_phase_q <= 1'b0;
      row_sel_q     <= '0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      // Non-blocking: a load coinciding with the transfer lands one frame later.
      if (xfer)   active_q <= shadow_q;
      if (load_i) shadow_q <= '{p: tile_map_t'(tiles_p_i), g: tile_map_t'(tiles_g_i),
                                blink: tile_map_t'(blink_mask_i)};
      if (state_q == DRIVE) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      blink_div_q <= blink_div_q + BLINK_DIV_BITS'(1);
      if (&blink_div_q) blink_phase_q <= ~blink_phase_q;
      row_sel_q    <= drive ? (ROWS'(1) << row_q) : '0;
      frame_done_q <= frame_end;
      busy_q       <= enable_i & (state_q != IDLE);
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    tsm_col_lane u_lane (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .drive_i       (drive),
      .pwm_on_i      (pwm_on),
      .blink_phase_i (blink_phase_q),
      .p_i           (active_q.p[row_q][c]),
      .g_i           (active_q.g[row_q][c]),
      .blink_i       (active_q.blink[row_q][c]),
      .col_p_o       (col_p_o[c]),
      .col_g_o       (col_g_o[c])
    );
  end

  assign row_sel_o    = row_sel_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_tile_matrix_scanner.sv
// Bench for tile_matrix_scanner: frame-position reference model checked every cycle,
// plus directed literal expectations for timing, PWM, blink, double buffer and enable.

module tb_tile_matrix_scanner;
  localparam int R = 2, C = 3, D = 8, B = 2, PB = 2, BD = 5;
  localparam int SLOT = B + D, FRAME = R * SLOT;

  logic clk = 1'b0, rst_n;
  logic enable, load;
  logic [R*C-1:0] tiles_p, tiles_g, blink_mask;
  logic [PB-1:0] brightness;
  logic [R-1:0] row_sel;
  logic [C-1:0] col_p, col_g;
  logic frame_done, busy;
  logic [9:0] outs;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  tile_matrix_scanner #(
    .ROWS(R), .COLS(C), .DWELL_CYCLES(D), .BLANK_CYCLES(B), .PWM_BITS(PB), .BLINK_DIV_BITS(BD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .load_i(load),
    .tiles_p_i(tiles_p), .tiles_g_i(tiles_g), .blink_mask_i(blink_mask), .brightness_i(brightness),
    .row_sel_o(row_sel), .col_p_o(col_p), .col_g_o(col_g), .frame_done_o(frame_done), .busy_o(busy)
  );

  assign outs = {row_sel, col_p, col_g, frame_done, busy};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
  endtask

  // Model: scan position within the frame, counts of drive cycles and clock edges.
  bit m_run;
  int m_pos, m_pwm, m_blk;
  logic [R*C-1:0] sh_p, sh_g, sh_b, ac_p, ac_g, ac_b;
  logic [R-1:0] e_row;
  logic [C-1:0] e_cp, e_cg;
  logic e_fd, e_busy;

  always @(posedge clk or negedge rst_n) begin : model
    int fp, r, off, t;
    bit drv, last, ph, pon, lit;
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_pwm = 0; m_blk = 0;
      sh_p = '0; sh_g = '0; sh_b = '0; ac_p = '0; ac_g = '0; ac_b = '0;
      e_row = '0; e_cp = '0; e_cg = '0; e_fd = 0; e_busy = 0;
    end else begin
      fp   = m_pos % FRAME;
      r    = fp / SLOT;
      off  = fp % SLOT;
      drv  = m_run && (off >= B);
      last = m_run && (fp == FRAME - 1);
      ph   = ((m_blk / 32) % 2) == 1;
      pon  = (brightness == 2'd3) || ((m_pwm % 4) < int'(brightness));
      e_row = '0; e_cp = '0; e_cg = '0; e_fd = 0; e_busy = 0;
      if (enable) begin
        e_busy = m_run;
        e_fd   = last;
        if (drv) begin
          e_row = 2'b01 << r;
          for (int c = 0; c < C; c++) begin
            t   = r * C + c;
            lit = pon && !(ac_b[t] && ph);
            e_cp[c] = ac_p[t] && lit;
            e_cg[c] = ac_g[t] && lit;
          end
        end
      end
      if (drv) m_pwm++;
      if (enable && (!m_run || last)) begin
        ac_p = sh_p; ac_g = sh_g; ac_b = sh_b;
      end
      if (load) begin
        sh_p = tiles_p; sh_g = tiles_g; sh_b = blink_mask;
      end
      if (!enable) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
      m_blk++;
    end
  end

  always @(negedge clk)
    if (rst_n) check("model", {22'd0, outs}, {22'd0, e_row, e_cp, e_cg, e_fd, e_busy});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [R-1:0] xr;
    logic [C-1:0] xp, xg;
    int cnt0, cnt1, guard, offc;
    rst_n = 0; enable = 0; load = 0; tiles_p = '0; tiles_g = '0; blink_mask = '0; brightness = '0;
    repeat (3) tick();
    check("reset_outs", {22'd0, outs}, 32'd0);
    rst_n = 1;
    tick();

    // Scan timing with a fixed pattern at full brightness.
    tiles_p = 6'b101_010; tiles_g = 6'b011_100; brightness = 2'd3; load = 1;
    tick();
    load = 0; enable = 1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      xr = ((k >= 4 && k <= 11) || k == 24) ? 2'b01 : (k >= 14 && k <= 21) ? 2'b10 : 2'b00;
      xp = (xr == 2'b01) ? 3'b010 : (xr == 2'b10) ? 3'b101 : 3'b000;
      xg = (xr == 2'b01) ? 3'b100 : (xr == 2'b10) ? 3'b011 : 3'b000;
      check($sformatf("scan%0d", k), {22'd0, outs}, {22'd0, xr, xp, xg, (k == 21), (k >= 2)});
    end

    // Asynchronous reset in row 1 of the second frame.
    repeat (13) tick();
    check("pre_rst_row1", {30'd0, row_sel}, 32'b10);
    rst_n = 0; enable = 0;
    #1;
    check("async_rst", {22'd0, outs}, 32'd0);
    tick();
    rst_n = 1;

    // PWM duty over one full frame.
    tiles_p = 6'b000_001; tiles_g = '0; blink_mask = '0; brightness = 2'd1; load = 1;
    tick();
    load = 0; enable = 1;
    repeat (45) tick();
    foreach (xr[i]) xr[i] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      brightness = (b == 0) ? 2'd1 : (b == 1) ? 2'd0 : 2'd3;
      cnt0 = 0;
      repeat (FRAME) begin tick(); cnt0 += int'(col_p[0]); end
      check($sformatf("pwm_b%0d", brightness), cnt0, (b == 0) ? 2 : (b == 1) ? 0 : 8);
    end

    // Blink: tile0 blinks, tile1 steady.
    tiles_p = 6'b000_011; blink_mask = 6'b000_001; load = 1;
    tick();
    load = 0;
    repeat (45) tick();
    cnt0 = 0; cnt1 = 0;
    repeat (4 * FRAME) begin tick(); cnt0 += int'(col_p[0]); cnt1 += int'(col_p[1]); end
    check("blink_steady", cnt1, 32);
    check("blink_partial", {31'd0, (cnt0 > 0 && cnt0 < 32)}, 32'd1);

    // Load coincident with the frame-end transfer.
    tiles_p = 6'b000_010; blink_mask = '0; load = 1;
    tick();
    load = 0;
    repeat (45) tick();
    guard = 0;
    while (!frame_done && guard < 60) begin tick(); guard++; end
    check("fd_seen", {31'd0, frame_done}, 32'd1);
    repeat (39) tick();
    tiles_p = 6'b000_100; load = 1;
    tick();
    load = 0;
    check("coinc_fd", {31'd0, frame_done}, 32'd1);
    repeat (5) tick();
    check("coinc_old", {27'd0, row_sel, col_p}, {27'd0, 2'b01, 3'b010});
    repeat (40) tick();
    check("coinc_new", {27'd0, row_sel, col_p}, {27'd0, 2'b01, 3'b100});

    // Load mid-row 0 is deferred to the next frame.
    tiles_p = 6'b000_001; load = 1;
    tick();
    load = 0;
    check("midrow_hold", {27'd0, row_sel, col_p}, {27'd0, 2'b01, 3'b100});
    repeat (39) tick();
    check("midrow_next", {27'd0, row_sel, col_p}, {27'd0, 2'b01, 3'b001});

    // Enable drop mid-row and restart.
    enable = 0;
    tick();
    check("en_drop", {22'd0, outs}, 32'd0);
    repeat (3) tick();
    check("en_idle", {22'd0, outs}, 32'd0);
    enable = 1;
    repeat (4) tick();
    check("en_restart", {22'd0, outs}, {22'd0, 2'b01, 3'b001, 3'b000, 1'b0, 1'b1});

    // Randomised traffic against the model.
    offc = 0;
    repeat (3000) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        tiles_p = R*C'($urandom); tiles_g = R*C'($urandom); blink_mask = R*C'($urandom);
      end
      if ($urandom_range(0, 63) == 0) brightness = PB'($urandom);
      if (offc > 0) offc--;
      else if ($urandom_range(0, 149) == 0) offc = $urandom_range(1, 6);
      enable = (offc == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
